// File: rtl/stencil_fill_arbiter.sv
// Stencil fill arbiter: sequences a full-mode block fill into the stencil
// cache while sharing the cache ports with the rasterizer.  The rasterizer
// normally wins every cycle it is active; fill writes use the idle cycles.
// Optional build macro STENCIL_FILL_STARVE_GUARD_EN adds a starvation guard
// that steals one raster cycle after 15 consecutive raster-won FILL cycles.
module stencil_fill_arbiter (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_fillReq,
    input  logic [14:0] i_fillStartAdr,
    input  logic [15:0] i_fillCount,
    input  logic [15:0] i_fillValue,
    output logic        o_fillBusy,
    output logic        o_fillDone,
    input  logic        i_rasWriteSig,
    input  logic [14:0] i_rasWriteAdr,
    input  logic [2:0]  i_rasWritePair,
    input  logic [1:0]  i_rasWriteSelect,
    input  logic [1:0]  i_rasWriteValue,
    input  logic        i_rasReadSig,
    input  logic [14:0] i_rasReadAdr,
    input  logic [2:0]  i_rasReadPair,
    input  logic [1:0]  i_rasReadSelect,
    output logic        o_rasStall,
    output logic        o_fullMode,
    output logic [15:0] o_writeValue16,
    output logic [15:0] o_writeMask16,
    output logic        o_stencilWriteSig,
    output logic [14:0] o_stencilWriteAdr,
    output logic [2:0]  o_stencilWritePair,
    output logic [1:0]  o_stencilWriteSelect,
    output logic [1:0]  o_stencilWriteValue,
    output logic        o_stencilReadSig,
    output logic [14:0] o_stencilReadAdr,
    output logic [2:0]  o_stencilReadPair,
    output logic [1:0]  o_stencilReadSelect
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [14:0] fillPtr;
    logic [15:0] fillRemain;
    logic [15:0] fillVal;
    logic        rasCycle;
    logic        forceFill;
    logic        fillWrite;
    logic        fillAccept;

    assign rasCycle   = i_rasWriteSig | i_rasReadSig;
    assign fillAccept = (state == IDLE) && i_fillReq && (i_fillCount != '0);

`ifdef STENCIL_FILL_STARVE_GUARD_EN
    logic [3:0] starveCnt;

    // Once 15 raster cycles in a row have beaten the fill, the next one is stolen.
    assign forceFill = (state == FILL) && rasCycle && (starveCnt == 4'd15);

    // Count consecutive raster-won FILL cycles; any fill write restarts the count.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst)
            starveCnt <= '0;
        else if (fillWrite)
            starveCnt <= '0;
        else if ((state == FILL) && rasCycle && (starveCnt != 4'd15))
            starveCnt <= starveCnt + 4'd1;
    end
`else
    assign forceFill = 1'b0;
`endif

    assign fillWrite  = (state == FILL) && (!rasCycle || forceFill);
    assign o_rasStall = forceFill;
    assign o_fillBusy = (state == FILL);
    assign o_fillDone = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state: a zero-count request goes straight to DONE without writing.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (i_fillReq) stateNext = (i_fillCount != '0) ? FILL : DONE;
            FILL: if (fillWrite && (fillRemain == 16'd1)) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Fill pointer, remaining count and latched fill pattern.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            fillPtr    <= '0;
            fillRemain <= '0;
            fillVal    <= '0;
        end else if (fillAccept) begin
            fillPtr    <= i_fillStartAdr;
            fillRemain <= i_fillCount;
            fillVal    <= i_fillValue;
        end else if (fillWrite) begin
            fillPtr    <= fillPtr + 15'd1;
            fillRemain <= fillRemain - 16'd1;
        end
    end

    // Cache port mux: raster passes through unless this is a fill-write cycle.
    always_comb begin
        o_fullMode           = 1'b0;
        o_writeValue16       = '0;
        o_writeMask16        = '0;
        o_stencilWriteSig    = i_rasWriteSig;
        o_stencilWriteAdr    = i_rasWriteAdr;
        o_stencilWritePair   = i_rasWritePair;
        o_stencilWriteSelect = i_rasWriteSelect;
        o_stencilWriteValue  = i_rasWriteValue;
        o_stencilReadSig     = i_rasReadSig;
        o_stencilReadAdr     = i_rasReadAdr;
        o_stencilReadPair    = i_rasReadPair;
        o_stencilReadSelect  = i_rasReadSelect;
        if (fillWrite) begin
            o_fullMode           = 1'b1;
            o_writeValue16       = fillVal;
            o_writeMask16        = '1;
            o_stencilWriteSig    = 1'b1;
            o_stencilWriteAdr    = fillPtr;
            o_stencilWritePair   = '0;
            o_stencilWriteSelect = '0;
            o_stencilWriteValue  = '0;
            o_stencilReadSig     = 1'b0;
            o_stencilReadAdr     = '0;
            o_stencilReadPair    = '0;
            o_stencilReadSelect  = '0;
        end
    end

endmodule

// File: tb/tb_stencil_fill_arbiter.sv
// Scoreboard bench for stencil_fill_arbiter.  Stimulus pushes the expected
// cache-port event (with its cycle number) for every cycle it expects one;
// the monitor pops and compares on every cycle the DUT shows an event.
module tb_stencil_fill_arbiter;

    logic        clk = 1'b0;
    logic        i_nrst;
    logic        i_fillReq;
    logic [14:0] i_fillStartAdr;
    logic [15:0] i_fillCount;
    logic [15:0] i_fillValue;
    logic        o_fillBusy;
    logic        o_fillDone;
    logic        i_rasWriteSig;
    logic [14:0] i_rasWriteAdr;
    logic [2:0]  i_rasWritePair;
    logic [1:0]  i_rasWriteSelect;
    logic [1:0]  i_rasWriteValue;
    logic        i_rasReadSig;
    logic [14:0] i_rasReadAdr;
    logic [2:0]  i_rasReadPair;
    logic [1:0]  i_rasReadSelect;
    logic        o_rasStall;
    logic        o_fullMode;
    logic [15:0] o_writeValue16;
    logic [15:0] o_writeMask16;
    logic        o_stencilWriteSig;
    logic [14:0] o_stencilWriteAdr;
    logic [2:0]  o_stencilWritePair;
    logic [1:0]  o_stencilWriteSelect;
    logic [1:0]  o_stencilWriteValue;
    logic        o_stencilReadSig;
    logic [14:0] o_stencilReadAdr;
    logic [2:0]  o_stencilReadPair;
    logic [1:0]  o_stencilReadSelect;

    stencil_fill_arbiter dut (
        .clk(clk), .i_nrst(i_nrst),
        .i_fillReq(i_fillReq), .i_fillStartAdr(i_fillStartAdr),
        .i_fillCount(i_fillCount), .i_fillValue(i_fillValue),
        .o_fillBusy(o_fillBusy), .o_fillDone(o_fillDone),
        .i_rasWriteSig(i_rasWriteSig), .i_rasWriteAdr(i_rasWriteAdr),
        .i_rasWritePair(i_rasWritePair), .i_rasWriteSelect(i_rasWriteSelect),
        .i_rasWriteValue(i_rasWriteValue),
        .i_rasReadSig(i_rasReadSig), .i_rasReadAdr(i_rasReadAdr),
        .i_rasReadPair(i_rasReadPair), .i_rasReadSelect(i_rasReadSelect),
        .o_rasStall(o_rasStall), .o_fullMode(o_fullMode),
        .o_writeValue16(o_writeValue16), .o_writeMask16(o_writeMask16),
        .o_stencilWriteSig(o_stencilWriteSig), .o_stencilWriteAdr(o_stencilWriteAdr),
        .o_stencilWritePair(o_stencilWritePair), .o_stencilWriteSelect(o_stencilWriteSelect),
        .o_stencilWriteValue(o_stencilWriteValue),
        .o_stencilReadSig(o_stencilReadSig), .o_stencilReadAdr(o_stencilReadAdr),
        .o_stencilReadPair(o_stencilReadPair), .o_stencilReadSelect(o_stencilReadSelect)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        fullMode;
        logic        wrSig;
        logic        rdSig;
        logic        done;
        logic        stall;
        logic        busy;
        logic [14:0] adr;
        logic [15:0] val16;
        logic [15:0] mask16;
        logic [2:0]  pair;
        logic [1:0]  sel;
        logic [1:0]  wv;
    } ev_t;

    ev_t expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkBase(int c);
        ev_t e;
        e.cyc = c; e.fullMode = 0; e.wrSig = 0; e.rdSig = 0; e.done = 0;
        e.stall = 0; e.busy = 0; e.adr = '0; e.val16 = '0; e.mask16 = '0;
        e.pair = '0; e.sel = '0; e.wv = '0;
        return e;
    endfunction

    function automatic ev_t mkFill(int c, logic [14:0] adr, logic [15:0] v, logic stall);
        ev_t e = mkBase(c);
        e.fullMode = 1; e.wrSig = 1; e.busy = 1; e.stall = stall;
        e.adr = adr; e.val16 = v; e.mask16 = 16'hFFFF;
        return e;
    endfunction

    function automatic ev_t mkRasWr(int c, logic [14:0] adr, logic [2:0] p,
                                    logic [1:0] s, logic [1:0] wv, logic busy);
        ev_t e = mkBase(c);
        e.wrSig = 1; e.busy = busy; e.adr = adr; e.pair = p; e.sel = s; e.wv = wv;
        return e;
    endfunction

    function automatic ev_t mkRasRd(int c, logic [14:0] adr, logic [2:0] p,
                                    logic [1:0] s, logic busy);
        ev_t e = mkBase(c);
        e.rdSig = 1; e.busy = busy; e.adr = adr; e.pair = p; e.sel = s;
        return e;
    endfunction

    function automatic ev_t mkDone(int c);
        ev_t e = mkBase(c);
        e.done = 1;
        return e;
    endfunction

    function automatic bit evEq(ev_t a, ev_t b);
        return a.cyc == b.cyc && a.fullMode === b.fullMode && a.wrSig === b.wrSig &&
               a.rdSig === b.rdSig && a.done === b.done && a.stall === b.stall &&
               a.busy === b.busy && a.adr === b.adr && a.val16 === b.val16 &&
               a.mask16 === b.mask16 && a.pair === b.pair && a.sel === b.sel &&
               a.wv === b.wv;
    endfunction

    // Monitor: any cache access, done pulse or stall is an event to score.
    always @(negedge clk) begin
        if (i_nrst && (o_stencilWriteSig || o_stencilReadSig || o_fillDone || o_rasStall)) begin
            ev_t a;
            ev_t e;
            a.cyc = cyc; a.fullMode = o_fullMode; a.wrSig = o_stencilWriteSig;
            a.rdSig = o_stencilReadSig; a.done = o_fillDone; a.stall = o_rasStall;
            a.busy = o_fillBusy;
            a.adr  = o_stencilWriteSig ? o_stencilWriteAdr : o_stencilReadAdr;
            a.val16 = o_writeValue16; a.mask16 = o_writeMask16;
            a.pair = o_stencilWriteSig ? o_stencilWritePair : o_stencilReadPair;
            a.sel  = o_stencilWriteSig ? o_stencilWriteSelect : o_stencilReadSelect;
            a.wv   = o_stencilWriteValue;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d fm=%b wr=%b rd=%b done=%b stall=%b adr=%h val=%h required none",
                         a.cyc, a.fullMode, a.wrSig, a.rdSig, a.done, a.stall, a.adr, a.val16);
            end else begin
                e = expQ.pop_front();
                if (!evEq(a, e)) begin
                    errors++;
                    $display("FAIL event got cyc=%0d fm=%b wr=%b rd=%b dn=%b st=%b bz=%b adr=%h v=%h m=%h p=%0d s=%0d wv=%0d required cyc=%0d fm=%b wr=%b rd=%b dn=%b st=%b bz=%b adr=%h v=%h m=%h p=%0d s=%0d wv=%0d",
                             a.cyc, a.fullMode, a.wrSig, a.rdSig, a.done, a.stall, a.busy, a.adr, a.val16, a.mask16, a.pair, a.sel, a.wv,
                             e.cyc, e.fullMode, e.wrSig, e.rdSig, e.done, e.stall, e.busy, e.adr, e.val16, e.mask16, e.pair, e.sel, e.wv);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_events got_pending=%0d required=0", name, expQ.size());
            expQ.delete();
        end
        step();
        step();
    endtask

    task automatic startFill(logic [14:0] adr, logic [15:0] cnt, logic [15:0] v);
        i_fillReq = 1; i_fillStartAdr = adr; i_fillCount = cnt; i_fillValue = v;
    endtask

    task automatic clrRas();
        i_rasWriteSig = 0; i_rasWriteAdr = '0; i_rasWritePair = '0;
        i_rasWriteSelect = '0; i_rasWriteValue = '0;
        i_rasReadSig = 0; i_rasReadAdr = '0; i_rasReadPair = '0; i_rasReadSelect = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        i_nrst = 0;
        i_fillReq = 0; i_fillStartAdr = '0; i_fillCount = '0; i_fillValue = '0;
        clrRas();
        step();
        step();

        chk("reset_busy",  {31'd0, o_fillBusy}, 32'd0);
        chk("reset_done",  {31'd0, o_fillDone}, 32'd0);
        chk("reset_stall", {31'd0, o_rasStall}, 32'd0);
        chk("reset_fullmode", {31'd0, o_fullMode}, 32'd0);
        chk("reset_mask",  {16'd0, o_writeMask16}, 32'd0);
        i_nrst = 1;
        step();

        // Basic fill of 4 words.
        startFill(15'h0010, 16'd4, 16'hA5A5);
        c = cyc;
        for (int k = 0; k < 4; k++) expQ.push_back(mkFill(c + 1 + k, 15'h0010 + 15'(k), 16'hA5A5, 0));
        expQ.push_back(mkDone(c + 5));
        step();
        i_fillReq = 0;
        drain("fill4");

        // Address wrap.
        startFill(15'h7FFE, 16'd3, 16'h1234);
        c = cyc;
        expQ.push_back(mkFill(c + 1, 15'h7FFE, 16'h1234, 0));
        expQ.push_back(mkFill(c + 2, 15'h7FFF, 16'h1234, 0));
        expQ.push_back(mkFill(c + 3, 15'h0000, 16'h1234, 0));
        expQ.push_back(mkDone(c + 4));
        step();
        i_fillReq = 0;
        drain("wrap");

        // Raster read in IDLE passes through.
        i_rasReadSig = 1; i_rasReadAdr = 15'h0ABC; i_rasReadPair = 3'd3; i_rasReadSelect = 2'd1;
        expQ.push_back(mkRasRd(cyc, 15'h0ABC, 3'd3, 2'd1, 0));
        step();
        clrRas();
        drain("idle_read");

        // Raster write holds off the fill for three cycles.
        startFill(15'h0200, 16'd2, 16'h0F0F);
        c = cyc;
        for (int k = 1; k <= 3; k++) expQ.push_back(mkRasWr(c + k, 15'h1234, 3'd5, 2'd2, 2'd3, 1));
        expQ.push_back(mkFill(c + 4, 15'h0200, 16'h0F0F, 0));
        expQ.push_back(mkFill(c + 5, 15'h0201, 16'h0F0F, 0));
        expQ.push_back(mkDone(c + 6));
        step();
        i_fillReq = 0;
        i_rasWriteSig = 1; i_rasWriteAdr = 15'h1234; i_rasWritePair = 3'd5;
        i_rasWriteSelect = 2'd2; i_rasWriteValue = 2'd3;
        step();
        step();
        step();
        clrRas();
        drain("raster_priority");

        // Twenty consecutive raster cycles during a fill of 3.
        startFill(15'h0300, 16'd3, 16'hC3C3);
        c = cyc;
`ifdef STENCIL_FILL_STARVE_GUARD_EN
        for (int k = 1; k <= 15; k++) expQ.push_back(mkRasWr(c + k, 15'h0111, 3'd1, 2'd1, 2'd1, 1));
        expQ.push_back(mkFill(c + 16, 15'h0300, 16'hC3C3, 1));
        for (int k = 17; k <= 20; k++) expQ.push_back(mkRasWr(c + k, 15'h0111, 3'd1, 2'd1, 2'd1, 1));
        expQ.push_back(mkFill(c + 21, 15'h0301, 16'hC3C3, 0));
        expQ.push_back(mkFill(c + 22, 15'h0302, 16'hC3C3, 0));
        expQ.push_back(mkDone(c + 23));
`else
        for (int k = 1; k <= 20; k++) expQ.push_back(mkRasWr(c + k, 15'h0111, 3'd1, 2'd1, 2'd1, 1));
        expQ.push_back(mkFill(c + 21, 15'h0300, 16'hC3C3, 0));
        expQ.push_back(mkFill(c + 22, 15'h0301, 16'hC3C3, 0));
        expQ.push_back(mkFill(c + 23, 15'h0302, 16'hC3C3, 0));
        expQ.push_back(mkDone(c + 24));
`endif
        step();
        i_fillReq = 0;
        i_rasWriteSig = 1; i_rasWriteAdr = 15'h0111; i_rasWritePair = 3'd1;
        i_rasWriteSelect = 2'd1; i_rasWriteValue = 2'd1;
        for (int k = 0; k < 20; k++) step();
        clrRas();
        drain("starve");

        // Zero count: done pulse only, never busy.
        startFill(15'h0055, 16'd0, 16'hFFFF);
        expQ.push_back(mkDone(cyc + 1));
        step();
        i_fillReq = 0;
        drain("count_zero");

        // Reset after three writes of an 8-word fill.
        startFill(15'h0400, 16'd8, 16'h5555);
        c = cyc;
        for (int k = 0; k < 3; k++) expQ.push_back(mkFill(c + 1 + k, 15'h0400 + 15'(k), 16'h5555, 0));
        step();
        i_fillReq = 0;
        step();
        step();
        step();
        i_nrst = 0;
        #1;
        chk("midreset_busy", {31'd0, o_fillBusy}, 32'd0);
        chk("midreset_done", {31'd0, o_fillDone}, 32'd0);
        chk("midreset_fullmode", {31'd0, o_fullMode}, 32'd0);
        step();
        i_nrst = 1;
        chk("midreset_queue", expQ.size(), 32'd0);
        step();
        startFill(15'h0500, 16'd1, 16'h00FF);
        c = cyc;
        expQ.push_back(mkFill(c + 1, 15'h0500, 16'h00FF, 0));
        expQ.push_back(mkDone(c + 2));
        step();
        i_fillReq = 0;
        drain("after_reset");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
